// File: rtl/dac_spi_ctrl_pkg.sv
// rtl/dac_spi_ctrl_pkg.sv - shared encodings and defaults for the DAC SPI write controller
package dac_spi_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_CLK_DIV    = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_HIGH   = 3'd2,
        ST_LOW    = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    localparam logic [1:0] CNT_HOLD      = 2'b00;
    localparam logic [1:0] CNT_INC       = 2'b01;
    localparam logic [1:0] CNT_CLEAR     = 2'b10;
    localparam logic [1:0] CNT_CLEAR_ALT = 2'b11;

endpackage

// File: rtl/dac_spi_ctrl_bit_counter.sv
// rtl/dac_spi_ctrl_bit_counter.sv - frame bit counter with terminal flag at DataWidth
module dac_bit_counter
    import dac_spi_ctrl_pkg::*;
#(
    parameter int DataWidth = DEF_DATA_WIDTH,
    parameter int CntWidth  = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [1:0]          op,
    output logic [CntWidth-1:0] count,
    output logic                terminal
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count <= '0;
        end else begin
            case (op)
                CNT_INC:                  count <= count + 1'b1;
                CNT_CLEAR, CNT_CLEAR_ALT: count <= '0;
                default:                  count <= count;
            endcase
        end
    end

    assign terminal = (count == CntWidth'(DataWidth));

endmodule

// File: rtl/dac_spi_ctrl.sv
// rtl/dac_spi_ctrl.sv - serializes a parallel sample MSB-first onto SCLK/MOSI under active-low CS
module dac_spi_ctrl
    import dac_spi_ctrl_pkg::*;
#(
    parameter int DataWidth = DEF_DATA_WIDTH,
    parameter int ClkDiv    = DEF_CLK_DIV,
    parameter int CntWidth  = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [DataWidth-1:0] data_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 sclk_o,
    output logic                 mosi_o,
    output logic                 cs_n_o
);

    localparam int DivWidth = (ClkDiv > 1) ? $clog2(ClkDiv) : 1;
    localparam logic [DivWidth-1:0] DIV_LAST = DivWidth'(ClkDiv - 1);
    localparam logic [CntWidth-1:0] LAST_BIT = CntWidth'(DataWidth - 1);

    state_t                 state, next_state;
    logic [DivWidth-1:0]    div;
    logic [DataWidth-1:0]   shift, shift_next;
    logic [1:0]             cnt_op;
    logic [CntWidth-1:0]    bit_count;
    logic                   bit_terminal;
    logic                   div_last;

    assign div_last = (div == DIV_LAST);

    dac_bit_counter #(
        .DataWidth (DataWidth),
        .CntWidth  (CntWidth)
    ) u_bit_counter (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .op       (cnt_op),
        .count    (bit_count),
        .terminal (bit_terminal)
    );

    always_comb begin
        next_state = state;
        cnt_op     = CNT_HOLD;
        shift_next = shift;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    next_state = ST_SETUP;
                    cnt_op     = CNT_CLEAR;
                    shift_next = data_i;
                end
            end
            ST_SETUP: if (div_last) next_state = ST_HIGH;
            ST_HIGH:  if (div_last) next_state = ST_LOW;
            ST_LOW: begin
                if (div_last) begin
                    cnt_op = CNT_INC;
                    if (bit_count == LAST_BIT) begin
                        next_state = ST_FINISH;
                    end else begin
                        next_state = ST_HIGH;
                        shift_next = {shift[DataWidth-2:0], 1'b0};
                    end
                end
            end
            ST_FINISH: if (div_last && bit_terminal) next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= ST_IDLE;
            div    <= '0;
            shift  <= '0;
            cs_n_o <= 1'b1;
            sclk_o <= 1'b0;
            mosi_o <= 1'b0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            state  <= next_state;
            shift  <= shift_next;
            if (next_state != state || state == ST_IDLE || div_last) begin
                div <= '0;
            end else begin
                div <= div + 1'b1;
            end
            cs_n_o <= (next_state == ST_IDLE);
            sclk_o <= (next_state == ST_HIGH);
            mosi_o <= (next_state == ST_IDLE) ? 1'b0 : shift_next[DataWidth-1];
            busy_o <= (next_state != ST_IDLE);
            done_o <= (state == ST_FINISH) && (next_state == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_dac_spi_ctrl.sv
// tb/tb_dac_spi_ctrl.sv - scoreboard bench for dac_spi_ctrl at ClkDiv 4 and ClkDiv 2
module tb_dac_spi_ctrl;

    typedef struct {
        logic [15:0] data;
        int          low_len;
        int          gap;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [1:0]  start;
    logic [15:0] data_in [2];
    logic [1:0]  busy, done, sclk, mosi, cs_n;

    int checks = 0;
    int errors = 0;

    exp_t sb_q [2][$];

    int          m_rises   [2];
    int          m_low     [2];
    int          m_gap     [2];
    logic [15:0] m_bits    [2];
    logic        m_prev_cs [2];
    logic        m_prev_sc [2];
    logic        m_prev_dn [2];
    logic        m_active  [2];
    exp_t        m_cur     [2];

    dac_spi_ctrl #(.DataWidth(16), .ClkDiv(4), .CntWidth(5)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start[0]), .data_i(data_in[0]),
        .busy_o(busy[0]), .done_o(done[0]), .sclk_o(sclk[0]), .mosi_o(mosi[0]), .cs_n_o(cs_n[0])
    );

    dac_spi_ctrl #(.DataWidth(16), .ClkDiv(2), .CntWidth(5)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start[1]), .data_i(data_in[1]),
        .busy_o(busy[1]), .done_o(done[1]), .sclk_o(sclk[1]), .mosi_o(mosi[1]), .cs_n_o(cs_n[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Frame-level monitor: rebuilds each frame from the pins and compares against the queue head.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                if (m_active[i] && sb_q[i].size() > 0) void'(sb_q[i].pop_front());
                m_active[i]  = 1'b0;
                m_prev_cs[i] = 1'b1;
                m_prev_sc[i] = 1'b0;
                m_prev_dn[i] = 1'b0;
                m_gap[i]     = 0;
                m_low[i]     = 0;
                m_rises[i]   = 0;
            end else begin
                if (m_prev_cs[i] && !cs_n[i]) begin
                    if (sb_q[i].size() == 0) begin
                        chk($sformatf("unexpected_frame%0d", i), 32'd1, 32'd0);
                    end else begin
                        m_cur[i] = sb_q[i][0];
                        if (m_cur[i].gap != 0) chk($sformatf("cs_high_gap%0d", i), m_gap[i], m_cur[i].gap);
                        chk($sformatf("accept_outs%0d", i), {busy[i], sclk[i], mosi[i]},
                            {1'b1, 1'b0, m_cur[i].data[15]});
                    end
                    m_active[i] = 1'b1;
                    m_rises[i]  = 0;
                    m_low[i]    = 0;
                    m_bits[i]   = '0;
                end
                if (!cs_n[i]) begin
                    m_low[i]++;
                    if (!m_prev_sc[i] && sclk[i]) m_rises[i]++;
                    if (m_prev_sc[i] && !sclk[i]) m_bits[i] = {m_bits[i][14:0], mosi[i]};
                end
                if (!m_prev_cs[i] && cs_n[i] && m_active[i]) begin
                    if (sb_q[i].size() > 0) void'(sb_q[i].pop_front());
                    chk($sformatf("end_outs%0d", i), {done[i], busy[i], sclk[i]}, 3'b100);
                    chk($sformatf("data%0d", i), m_bits[i], m_cur[i].data);
                    chk($sformatf("sclk_rises%0d", i), m_rises[i], 16);
                    chk($sformatf("cs_low_len%0d", i), m_low[i], m_cur[i].low_len);
                    m_active[i] = 1'b0;
                    m_gap[i]    = 0;
                end
                if (cs_n[i]) m_gap[i]++;
                if (done[i] && (m_prev_dn[i] || !cs_n[i] || m_prev_cs[i]))
                    chk($sformatf("done_pulse%0d", i), 32'd0, 32'd1);
                m_prev_cs[i] = cs_n[i];
                m_prev_sc[i] = sclk[i];
                m_prev_dn[i] = done[i];
            end
        end
    end

    // Waits until the DUT can accept (or until done_o when on_done), then strobes one start.
    task automatic send(input int idx, input logic [15:0] d, input int gap, input bit on_done);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while ((on_done ? !done[idx] : busy[idx]) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            chk($sformatf("wait_timeout%0d", idx), 32'd1, 32'd0);
        end else begin
            e.data    = d;
            e.low_len = (idx == 0) ? 136 : 68;
            e.gap     = gap;
            sb_q[idx].push_back(e);
            data_in[idx] = d;
            start[idx]   = 1'b1;
            @(posedge clk);
            #1;
            start[idx] = 1'b0;
        end
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        start      = 2'b00;
        data_in[0] = '0;
        data_in[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++)
            chk($sformatf("reset_vals%0d", i), {cs_n[i], sclk[i], mosi[i], busy[i], done[i]}, 5'b10000);
        @(negedge clk);
        rst = 1'b0;

        send(0, 16'hA5C3, 0, 1'b0);
        send(0, 16'h0000, 0, 1'b0);
        send(0, 16'hFFFF, 0, 1'b0);

        send(0, 16'h1357, 0, 1'b0);
        repeat (29) @(posedge clk);
        #1;
        chk("bit3_high", sclk[0], 1'b1);
        data_in[0] = 16'h9BDF;
        start[0]   = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;

        send(0, 16'h0F0F, 0, 1'b0);
        send(0, 16'h1234, 1, 1'b1);

        send(0, 16'hC0DE, 0, 1'b0);
        repeat (61) @(posedge clk);
        #1;
        chk("bit7_high", sclk[0], 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_async", {cs_n[0], sclk[0], mosi[0], busy[0], done[0]}, 5'b10000);
        @(negedge clk);
        chk("rst_hold", {cs_n[0], sclk[0], mosi[0], busy[0], done[0]}, 5'b10000);
        #2;
        rst = 1'b0;
        repeat (150) @(negedge clk);
        chk("no_resume", {cs_n[0], busy[0], done[0]}, 3'b100);

        send(1, 16'hA5C3, 0, 1'b0);
        send(1, 16'h6E81, 0, 1'b0);

        n = 0;
        while ((sb_q[0].size() != 0 || sb_q[1].size() != 0 || busy != 2'b00) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drain", n < 2000, 1'b1);
        repeat (10) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dac_spi_ctrl.md
# dac_spi_ctrl

SPI write controller for the 16-bit DAC in the DAC/ADC/TX datapath. It accepts a parallel sample with a single-cycle start strobe and serializes it MSB-first onto SCLK/MOSI under an active-low chip select. It reports completion with a one-cycle done pulse. The block sits between the sample source (test pattern / UART receive path) and the DAC pins, and owns the bit-count counter that terminates each frame.

## Interface
- DataWidth, 16: bits per DAC frame; also the bit-counter terminal value.
- ClkDiv, 4: clk_i cycles per SCLK half-period (≥2).
- CntWidth, 5: bit-counter width; must hold DataWidth.

- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  start strobe; sampled only when idle.
- data_i  in  DataWidth  sample to send; captured on the accepting edge.
- busy_o  out  1  high from the cycle after acceptance until return to IDLE.
- done_o  out  1  one-cycle pulse on the first IDLE cycle after a frame.
- sclk_o  out  1  SPI clock; idles low.
- mosi_o  out  1  serial data, MSB first.
- cs_n_o  out  1  DAC chip select (SYNC), active-low.

## Operation
- States: IDLE, SETUP, HIGH, LOW, FINISH.
- IDLE: cs_n_o=1, sclk_o=0, busy_o=0.
  - start_i=1 loads data_i into the shift register, clears the bit counter, and moves to SETUP.
- SETUP: cs_n_o=0, sclk_o=0, mosi_o=shift[MSB]. After ClkDiv cycles, go to HIGH.
- HIGH: sclk_o=1 for ClkDiv cycles, then go to LOW.
  - The DAC samples MOSI on the HIGH→LOW SCLK edge.
- LOW: sclk_o=0 for ClkDiv cycles. On the last cycle:
  - increment the bit counter;
  - if count+1 == DataWidth, go to FINISH;
  - otherwise shift left by one and go to HIGH. MOSI changes on the same clk_i edge that SCLK rises.
- FINISH: cs_n_o=0, sclk_o=0 for ClkDiv cycles. Then go to IDLE with cs_n_o=1 and done_o=1 for one cycle.
- Half-period divider: counter 0..ClkDiv-1. It reloads on every state change, and each state exits on the terminal count.
- Bit counter ops:
  - hold: default;
  - inc: end of LOW;
  - clear: accept.
  - Terminal flag = (count == DataWidth).
- start_i while busy_o=1 is ignored. data_i is not re-sampled mid-frame.
- A start_i on the done_o cycle is accepted, giving a minimum CS-high time of one clk_i cycle.
- Reset, including mid-frame, immediately forces:
  - IDLE, cs_n_o=1, sclk_o=0, mosi_o=0, busy_o=0, done_o=0;
  - shift register, bit counter and divider all 0.
  - No partial frame resumes.

## Timing
- Reset values: cs_n_o=1, sclk_o=0, mosi_o=0, busy_o=0, done_o=0.
- Accept on edge E: cs_n_o low, busy_o high and mosi_o=data_i[DataWidth-1] are visible after E.
- First SCLK rise: ClkDiv cycles after cs_n_o falls.
- Bit period: 2·ClkDiv cycles. The SCLK falling edge is ClkDiv cycles after the rising edge, giving ≥ClkDiv-1 cycles of MOSI setup and hold.
- cs_n_o low duration: ClkDiv·(2·DataWidth+2) cycles (136 at defaults).
- Exactly DataWidth SCLK rising edges per frame. SCLK is low whenever cs_n_o toggles.
- done_o asserts in the same cycle cs_n_o returns high and busy_o falls.
- Start-to-done latency: ClkDiv·(2·DataWidth+2)+1 cycles.

## Structure
- Shared package holds:
  - the state encoding (5 states, 3-bit);
  - the bit-counter op codes (00 hold, 01 inc, 10 clear, 11 clear);
  - default DataWidth and ClkDiv.
- Sub-module: dac_bit_counter, a CntWidth up-counter with 2-bit op input and terminal flag at DataWidth. The FSM drives its op and consumes the flag.
- The divider, shift register and output registers live in the top. All outputs are registered (no glitches on sclk_o or cs_n_o).

## Test plan
- Reset: hold rst_i mid-frame (bit 7, sclk_o=1) → next cycle cs_n_o=1, sclk_o=0, mosi_o=0, busy_o=0; no done_o.
- Single frame with data_i=16'hA5C3, ClkDiv=4 → 16 SCLK rises, bits sampled at falling edges = A5C3 MSB-first, cs_n_o low 136 cycles, done_o one pulse at cycle 137.
- Patterns 16'h0000 and 16'hFFFF → mosi_o constant for the whole frame. Counter terminates after exactly 16 bits; no 17th SCLK edge.
- start_i pulsed at bit 3 with different data_i → ignored; frame completes with the original data.
- Back-to-back: start_i on the done_o cycle with 16'h1234 → accepted; cs_n_o high exactly 1 cycle; second frame correct.
- ClkDiv=2 with DataWidth=16 → bit period 4 cycles, cs_n_o low 68 cycles, data correct.
